// File: rtl/ipv4_header_builder.sv
// IPv4 header generator: one 20-byte header (IHL=5, no options) per payload-length token,
// with internally computed total length, header checksum and Identification field.
module ipv4_header_builder #(
  parameter int          AXIS_BYTES      = 1,
  parameter bit          IDENT_INCREMENT = 1'b1,
  parameter logic [15:0] IDENT_INIT      = 16'h0000,
  parameter bit          DONT_FRAGMENT   = 1'b1
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic [31:0]               src_ip,
  input  logic [31:0]               dest_ip,
  input  logic [7:0]                protocol,
  input  logic [7:0]                ttl,
  input  logic [7:0]                dscp_ecn,
  output logic                      payload_length_axis_tready,
  input  logic                      payload_length_axis_tvalid,
  input  logic [15:0]               payload_length_axis_tdata,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic                      length_err
);

  localparam int unsigned W         = 8 * AXIS_BYTES;
  localparam int unsigned NBEATS    = 20 / AXIS_BYTES;
  localparam logic [4:0]  LAST_BEAT = 5'(NBEATS - 1);

  if (AXIS_BYTES != 1 && AXIS_BYTES != 2 && AXIS_BYTES != 4) begin : g_bad_width
    $error("ipv4_header_builder: AXIS_BYTES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CSUM, EMIT} state_t;

  state_t        state, state_next;
  logic [31:0]   src_q, dst_q;
  logic [7:0]    proto_q, ttl_q, dscp_q;
  logic [15:0]   total_q, ident_q, ident;
  logic [3:0]    word_idx;
  logic [19:0]   acc, sum;
  logic [16:0]   fold1;
  logic [15:0]   fold2, csum, word;
  logic [4:0]    beat;
  logic [159:0]  emit_q;
  logic          accept, beat_done;

  assign accept    = payload_length_axis_tready & payload_length_axis_tvalid;
  assign beat_done = axis_o_tvalid & axis_o_tready;

  always_ff @(posedge clk) begin
    if (sreset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next                 = state;
    payload_length_axis_tready = 1'b0;
    axis_o_tvalid              = 1'b0;
    axis_o_tlast               = 1'b0;
    case (state)
      IDLE: begin
        payload_length_axis_tready = ~sreset;
        if (payload_length_axis_tvalid && !sreset) state_next = CSUM;
      end
      CSUM: begin
        if (word_idx == 4'd9) state_next = EMIT;
      end
      EMIT: begin
        axis_o_tvalid = 1'b1;
        axis_o_tlast  = (beat == LAST_BEAT);
        if (axis_o_tready && beat == LAST_BEAT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Header words in wire order with the checksum word (index 5) taken as zero.
  always_comb begin
    word = '0;
    case (word_idx)
      4'd0:    word = {8'h45, dscp_q};
      4'd1:    word = total_q;
      4'd2:    word = ident_q;
      4'd3:    word = {1'b0, DONT_FRAGMENT, 14'd0};
      4'd4:    word = {ttl_q, proto_q};
      4'd6:    word = src_q[31:16];
      4'd7:    word = src_q[15:0];
      4'd8:    word = dst_q[31:16];
      4'd9:    word = dst_q[15:0];
      default: word = '0;
    endcase
  end

  // Ten 16-bit words cannot overflow 20 bits; two end-around folds settle all carries.
  assign sum   = acc + {4'd0, word};
  assign fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign csum  = ~fold2;

  always_ff @(posedge clk) begin
    if (sreset) begin
      ident      <= IDENT_INIT;
      length_err <= 1'b0;
      word_idx   <= '0;
      acc        <= '0;
      beat       <= '0;
      emit_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      proto_q    <= '0;
      ttl_q      <= '0;
      dscp_q     <= '0;
      total_q    <= '0;
      ident_q    <= '0;
    end else begin
      length_err <= accept && (payload_length_axis_tdata > 16'd65515);
      case (state)
        IDLE: begin
          if (accept) begin
            src_q    <= src_ip;
            dst_q    <= dest_ip;
            proto_q  <= protocol;
            ttl_q    <= ttl;
            dscp_q   <= dscp_ecn;
            ident_q  <= ident;
            total_q  <= payload_length_axis_tdata + 16'd20;
            word_idx <= '0;
            acc      <= '0;
          end
        end
        CSUM: begin
          acc      <= sum;
          word_idx <= word_idx + 4'd1;
          if (word_idx == 4'd9) begin
            emit_q <= {8'h45, dscp_q, total_q, ident_q, 1'b0, DONT_FRAGMENT, 6'd0, 8'h00,
                       ttl_q, proto_q, csum, src_q, dst_q};
            beat   <= '0;
          end
        end
        EMIT: begin
          if (beat_done) begin
            emit_q <= emit_q << W;
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (IDENT_INCREMENT) ident <= ident + 16'd1;
            end else begin
              beat <= beat + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign axis_o_tdata = axis_o_tvalid ? emit_q[159 -: W] : '0;

endmodule

// File: doc/ipv4_header_builder.md
Name: ipv4_header_builder

Overview:
- Generates a complete 20-byte IPv4 header (IHL=5, no options) as an AXI stream of configurable width, one header per payload-length token.
- Computes total length, header checksum and an optional per-packet incrementing Identification field internally with a single FSM. There is no broadcaster/FIFO network.
- Sits ahead of the payload joiner in the UDP/IP transmit path.

Parameters:
- AXIS_BYTES, 1, output beat width in octets. Legal values are 1, 2 and 4 (each divides 20). Any other value is an elaboration error.
- IDENT_INCREMENT, 1, 1 = Identification increments per header; 0 = Identification fixed at IDENT_INIT.
- IDENT_INIT, 16'h0000, Identification value after reset.
- DONT_FRAGMENT, 1, value of the DF flag. MF=0 and fragment offset=0 always.

Ports:
- clk  in  1  clock
- sreset  in  1  synchronous active-high reset
- src_ip  in  32  source address, sampled on length handshake
- dest_ip  in  32  destination address, sampled on length handshake
- protocol  in  8  protocol field, sampled on length handshake
- ttl  in  8  TTL field, sampled on length handshake
- dscp_ecn  in  8  octet 1 (DSCP/ECN), sampled on length handshake
- payload_length_axis_tready  out  1  length token accept
- payload_length_axis_tvalid  in  1  length token valid
- payload_length_axis_tdata  in  16  payload octet count (excluding header)
- axis_o_tready  in  1  downstream ready
- axis_o_tvalid  out  1  header beat valid
- axis_o_tlast  out  1  final header beat
- axis_o_tdata  out  8*AXIS_BYTES  header octets, first octet in MSBs
- length_err  out  1  one-cycle pulse: payload length > 65515

Behaviour:
- Reset values: state=IDLE, payload_length_axis_tready=0 for the reset cycle then 1 in IDLE, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, length_err=0, ident=IDENT_INIT.
- FSM IDLE -> CSUM -> EMIT -> IDLE.
- IDLE:
  - tready=1.
  - On tvalid&tready at cycle T, latch src_ip, dest_ip, protocol, ttl, dscp_ecn and the current ident.
  - Latch total_len = payload + 20, taken mod 2^16.
  - If payload > 65515, pulse length_err at T+1. The header is still emitted with the wrapped total_len.
  - Go to CSUM.
- CSUM:
  - tready=0.
  - Accumulate one 16-bit header word per cycle over the 10 words, with the checksum word taken as 0. This occupies cycles T+1..T+10.
  - Use a 20-bit accumulator. On the last add, fold the carries twice (end-around) and invert.
  - Store the result as checksum, then go to EMIT.
- EMIT:
  - tready=0.
  - First beat has tvalid=1 at cycle T+11.
  - 20/AXIS_BYTES beats, octets in wire order: 45, dscp_ecn, total_len[15:8], total_len[7:0], ident[15:8], ident[7:0], {0,DF,0,00000}, 00, ttl, protocol, csum[15:8], csum[7:0], src_ip MSB first, dest_ip MSB first.
  - Beat advances only on axis_o_tvalid&axis_o_tready. tdata/tvalid are held stable while stalled.
  - tlast=1 only on the final beat.
  - On the final handshake, go to IDLE. If IDENT_INCREMENT=1, ident <= ident+1, wrapping FFFF->0000.
  - tready returns to 1 in the cycle after the final handshake. Back-to-back headers are therefore spaced by ≥ 11 idle output cycles.
- Input fields changing after the handshake have no effect on the header in flight.
- Arbitrary back-pressure, including tready low for many cycles, produces no loss or duplication of beats.
- sreset asserted in any state:
  - Returns to IDLE and drops tvalid the next cycle.
  - The partial header is abandoned.
  - ident returns to IDENT_INIT.
  - A pending length_err pulse is cancelled.

Test Plan:
- Known-vector test:
  - Stimulus: AXIS_BYTES=1, IDENT_INIT=0, IDENT_INCREMENT=0, DF=1, payload=95, src=C0A80001, dst=C0A800C7, proto=11, ttl=40, dscp=00.
  - Required output: 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7.
  - tlast only on octet 20; first tvalid exactly 11 cycles after the length handshake.
- Width sweep: the same vector at AXIS_BYTES=2 and 4 -> 10 and 5 beats respectively; first beat 16'h4500 / 32'h45000073; tlast on the last beat only.
- Identification: IDENT_INCREMENT=1, IDENT_INIT=FFFE, three tokens -> ident fields FFFE, FFFF, 0000; each checksum is correct (independent model check).
- Back-pressure: random axis_o_tready at 30% duty with src_ip changed mid-emit -> output identical to the unstalled run; payload_length_axis_tready stays 0 until after the tlast handshake.
- Length edge cases:
  - payload=65515 -> total_len FFFF, length_err stays 0.
  - payload=65516 -> total_len 0000, one-cycle length_err at T+1.
- Reset mid-emit: assert sreset for 1 cycle during beat 7 -> tvalid=0 the next cycle; the next token yields a full header starting at octet 45 with ident=IDENT_INIT.
